// File: rtl/cpu_axil_bridge.sv
// cpu_axil_bridge: Ibex data port (req/gnt/rvalid) to AXI4-lite master.
// Carries one transaction at a time. The request is captured on grant and
// the response is registered and returned as a one-cycle data_rvalid pulse.
// Optional watchdog: define CPU_AXIL_BRIDGE_TIMEOUT_EN to abort a stalled
// AXI transaction after TIMEOUT cycles with data_err=1 and data_rdata=0.
module cpu_axil_bridge #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned SW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // CPU data port
  input  logic          data_req,
  output logic          data_gnt,
  output logic          data_rvalid,
  input  logic          data_we,
  input  logic [SW-1:0] data_be,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  // AXI4-lite write address
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  // AXI4-lite write data
  output logic [DW-1:0] wdata,
  output logic [SW-1:0] wstrb,
  output logic          wvalid,
  input  logic          wready,
  // AXI4-lite write response
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready,
  // AXI4-lite read address
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  // AXI4-lite read data
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_RESP
  } state_e;

  state_e        state_q;
  logic          awvalid_q;
  logic          wvalid_q;
  logic          bready_q;
  logic          arvalid_q;
  logic          rready_q;
  logic          rsp_valid_q;
  logic          err_q;
  logic [DW-1:0] rsp_data_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] awaddr_q;
  logic [AW-1:0] araddr_q;
  logic [SW-1:0] wstrb_q;

  logic          aw_done;
  logic          w_done;
  logic          busy;
  logic          abort;

  // Only the error bit of an AXI response is meaningful to the CPU.
  logic          unused_resp;
  assign unused_resp = bresp[0] ^ rresp[0];

  // Grant is combinational; at most one transaction is ever in flight.
  assign data_gnt = data_req & (state_q == S_IDLE);

  // A write channel is done once its valid has already dropped or it
  // handshakes in the current cycle.
  always_comb begin
    aw_done = !awvalid_q || awready;
    w_done  = !wvalid_q  || wready;
    busy    = (state_q == S_WR) || (state_q == S_WB) ||
              (state_q == S_RA) || (state_q == S_RD);
  end

`ifdef CPU_AXIL_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Watchdog cycle counter: cleared on grant, counts while waiting on AXI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (data_gnt) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fires in the cycle the counter would reach TIMEOUT, so the AXI valids
  // are already low in the cycle where the count equals TIMEOUT.
  assign abort = busy && (cnt_q == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT ^ busy;
  assign abort          = 1'b0;
`endif

  // Transaction FSM with registered AXI handshakes and CPU response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      wdata_q     <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wstrb_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_req) begin
            awaddr_q <= data_addr;
            araddr_q <= data_addr;
            wdata_q  <= data_wdata;
            wstrb_q  <= data_be;
            if (data_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RA;
            end
          end
        end
        S_WR: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            err_q       <= bresp[1];
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RA: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            err_q       <= rresp[1];
            rsp_data_q  <= rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Watchdog abort overrides whatever the state logic decided.
      if (abort) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        err_q       <= 1'b1;
        rsp_data_q  <= '0;
        rsp_valid_q <= 1'b1;
        state_q     <= S_RESP;
      end
    end
  end

  assign data_rvalid = rsp_valid_q;
  assign data_rdata  = rsp_data_q;
  assign data_err    = err_q;
  assign awaddr      = awaddr_q;
  assign awvalid     = awvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign araddr      = araddr_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Directed self-checking bench for cpu_axil_bridge. The AXI slave is driven
// cycle by cycle from the stimulus sequence.
module tb_cpu_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_axil_bridge #(
    .DW(32),
    .AW(32),
    .SW(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_req(data_req),
    .data_gnt(data_gnt),
    .data_rvalid(data_rvalid),
    .data_we(data_we),
    .data_be(data_be),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_err(data_err),
    .awaddr(awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata),
    .wstrb(wstrb),
    .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp),
    .bvalid(bvalid),
    .bready(bready),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read against a zero-wait slave: grant at T, AR at T+1, R at T+2,
  // data_rvalid at T+3, idle again at T+4.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [1:0] resp,
                         input logic exp_err);
    data_req = 1'b1; data_we = 1'b0; data_addr = addr;
    #1 chk({tag, ".gnt"}, 32'(data_gnt), 32'd1);
    step();
    data_req = 1'b0; arready = 1'b1;
    #1 chk({tag, ".arvalid"}, 32'(arvalid), 32'd1);
    chk({tag, ".araddr"}, araddr, addr);
    chk({tag, ".rvalid_early"}, 32'(data_rvalid), 32'd0);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = dat; rresp = resp;
    #1 chk({tag, ".arvalid_drop"}, 32'(arvalid), 32'd0);
    chk({tag, ".rready"}, 32'(rready), 32'd1);
    step();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    #1 chk({tag, ".data_rvalid"}, 32'(data_rvalid), 32'd1);
    chk({tag, ".data_rdata"}, data_rdata, dat);
    chk({tag, ".data_err"}, 32'(data_err), 32'(exp_err));
    chk({tag, ".rready_drop"}, 32'(rready), 32'd0);
    step();
    #1 chk({tag, ".rvalid_pulse"}, 32'(data_rvalid), 32'd0);
    chk({tag, ".rdata_hold"}, data_rdata, dat);
  endtask

  initial begin
    logic [9:0] gnt_exp;
    logic [9:0] rv_exp;

    rst = 1'b1;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;

    // Reset state
    step();
    step();
    chk("rst.awvalid", 32'(awvalid), 32'd0);
    chk("rst.wvalid", 32'(wvalid), 32'd0);
    chk("rst.arvalid", 32'(arvalid), 32'd0);
    chk("rst.bready", 32'(bready), 32'd0);
    chk("rst.rready", 32'(rready), 32'd0);
    chk("rst.data_rvalid", 32'(data_rvalid), 32'd0);
    chk("rst.data_rdata", data_rdata, 32'h0);
    chk("rst.awaddr", awaddr, 32'h0);
    chk("rst.wstrb", 32'(wstrb), 32'h0);
    rst = 1'b0;
    step();

    // Zero-wait read
    do_read("rd0", 32'h0000_4010, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // Write: wready immediate, awready only in the fourth AW-valid cycle
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3;
    data_addr = 32'h0000_4004; data_wdata = 32'h0000_1234;
    #1 chk("wr.gnt", 32'(data_gnt), 32'd1);
    step();
    data_req = 1'b0; data_we = 1'b0; wready = 1'b1;
    #1 chk("wr.t1.awvalid", 32'(awvalid), 32'd1);
    chk("wr.t1.wvalid", 32'(wvalid), 32'd1);
    chk("wr.wstrb", 32'(wstrb), 32'h3);
    chk("wr.wdata", wdata, 32'h0000_1234);
    chk("wr.awaddr", awaddr, 32'h0000_4004);
    step();
    wready = 1'b0;
    #1 chk("wr.t2.wvalid", 32'(wvalid), 32'd0);
    chk("wr.t2.awvalid", 32'(awvalid), 32'd1);
    chk("wr.t2.bready", 32'(bready), 32'd0);
    step();
    #1 chk("wr.t3.awvalid", 32'(awvalid), 32'd1);
    chk("wr.t3.bready", 32'(bready), 32'd0);
    step();
    awready = 1'b1;
    #1 chk("wr.t4.awvalid", 32'(awvalid), 32'd1);
    chk("wr.t4.bready", 32'(bready), 32'd0);
    step();
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    #1 chk("wr.t5.awvalid", 32'(awvalid), 32'd0);
    chk("wr.t5.bready", 32'(bready), 32'd1);
    step();
    bvalid = 1'b0;
    #1 chk("wr.data_rvalid", 32'(data_rvalid), 32'd1);
    chk("wr.data_err", 32'(data_err), 32'd0);
    chk("wr.data_rdata", data_rdata, 32'h0);
    chk("wr.bready_drop", 32'(bready), 32'd0);
    step();
    #1 chk("wr.rvalid_pulse", 32'(data_rvalid), 32'd0);

    // SLVERR then OKAY
    do_read("rd_slverr", 32'h0000_4100, 32'hCAFE_0001, 2'b10, 1'b1);
    do_read("rd_okay", 32'h0000_4104, 32'h0BAD_F00D, 2'b00, 1'b0);
    // DECERR and EXOKAY
    do_read("rd_decerr", 32'h0000_4108, 32'h1111_2222, 2'b11, 1'b1);
    do_read("rd_exokay", 32'h0000_410C, 32'h3333_4444, 2'b01, 1'b0);

    // Back-to-back with data_req held high; slave always ready.
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0011; rresp = 2'b00;
    gnt_exp = 10'b00_0001_0001;
    rv_exp  = 10'b00_1000_1000;
    for (int i = 0; i < 10; i++) begin
      data_req = (i <= 4); data_we = 1'b0; data_addr = 32'h0000_4200;
      #1 chk($sformatf("b2b.gnt[%0d]", i), 32'(data_gnt), 32'(gnt_exp[i]));
      chk($sformatf("b2b.rvalid[%0d]", i), 32'(data_rvalid), 32'(rv_exp[i]));
      step();
    end
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;

    // Async reset during WB
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
    data_addr = 32'h0000_4300; data_wdata = 32'hA5A5_A5A5;
    step();
    data_req = 1'b0; data_we = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1 chk("rstwb.bready", 32'(bready), 32'd1);
    rst = 1'b1;
    #1 chk("rstwb.bready_rst", 32'(bready), 32'd0);
    chk("rstwb.awaddr", awaddr, 32'h0);
    chk("rstwb.wdata", wdata, 32'h0);
    chk("rstwb.wstrb", 32'(wstrb), 32'h0);
    chk("rstwb.data_rdata", data_rdata, 32'h0);
    chk("rstwb.data_rvalid", 32'(data_rvalid), 32'd0);
    bvalid = 1'b1;
    step();
    rst = 1'b0; bvalid = 1'b0;
    #1 chk("rstwb.after.rvalid", 32'(data_rvalid), 32'd0);
    chk("rstwb.after.awvalid", 32'(awvalid), 32'd0);
    step();
    #1 chk("rstwb.after2.rvalid", 32'(data_rvalid), 32'd0);
    do_read("rd_post_rst", 32'h0000_4020, 32'h0000_55AA, 2'b00, 1'b0);

`ifdef CPU_AXIL_BRIDGE_TIMEOUT_EN
    // Slave never accepts AR: abort after 16 valid cycles.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_5000;
    #1 chk("to.gnt", 32'(data_gnt), 32'd1);
    step();
    data_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1 chk($sformatf("to.arvalid[%0d]", k), 32'(arvalid), 32'd1);
      chk($sformatf("to.rvalid[%0d]", k), 32'(data_rvalid), 32'd0);
      step();
    end
    #1 chk("to.arvalid_drop", 32'(arvalid), 32'd0);
    chk("to.data_rvalid", 32'(data_rvalid), 32'd1);
    chk("to.data_err", 32'(data_err), 32'd1);
    chk("to.data_rdata", data_rdata, 32'h0);
    step();
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    #1 chk("to.late.rready", 32'(rready), 32'd0);
    step();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    #1 chk("to.late.rvalid", 32'(data_rvalid), 32'd0);
    chk("to.late.rdata", data_rdata, 32'h0);
    do_read("rd_post_to", 32'h0000_5004, 32'h7777_8888, 2'b00, 1'b0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
